// File: rtl/sequence_player_pkg.sv
// Shared definitions for the memory-game sequence logic: playback FSM
// state encoding, default symbol width / sequence depth, and a small helper.
package sequence_player_pkg;

    localparam int DEFAULT_N     = 3;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHOW       = 2'd1,
        GAP        = 2'd2,
        WAIT_INPUT = 2'd3
    } play_state_t;

    // Larger of two integers, used to size the shared show/gap timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sequence_ram.sv
// DEPTH x N symbol store: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset; the owner tracks valid length.
module sequence_ram
    import sequence_player_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int LOG_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 write_en,
    input  logic [LOG_DEPTH-1:0] write_addr,
    input  logic [N-1:0]         write_data,
    input  logic [LOG_DEPTH-1:0] read_addr,
    output logic [N-1:0]         read_data
);

    logic [N-1:0] mem [DEPTH];

    // Store one symbol per write strobe.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/sequence_player.sv
// Stores the generated symbol sequence, plays it back to the display
// (SHOW_CYCLES lit + GAP_CYCLES blank per symbol), then checks presses in order.
//
// All control inputs (append, start, press) are single-cycle pulses sampled
// on the rising clock edge; there is no back-pressure. round_ok and mismatch
// are single-cycle result pulses registered on the edge that sampled press.
module sequence_player
    import sequence_player_pkg::*;
#(
    parameter int N           = DEFAULT_N,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int LOG_DEPTH   = 4,
    parameter int SHOW_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               append,
    input  logic [N-1:0]       symbol_in,
    input  logic               start,
    input  logic               press,
    input  logic [N-1:0]       press_symbol,
    output logic               show_valid,
    output logic [N-1:0]       show_symbol,
    output logic               busy,
    output logic               round_ok,
    output logic               mismatch,
    output logic               full,
    output logic [LOG_DEPTH:0] length
);

    localparam int TIMER_W = $clog2(max_int(SHOW_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [TIMER_W-1:0]   SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [LOG_DEPTH:0]   DEPTH_M1  = (LOG_DEPTH + 1)'(DEPTH - 1);
    localparam logic [LOG_DEPTH:0]   ONE       = (LOG_DEPTH + 1)'(1);

    play_state_t            state;
    logic [LOG_DEPTH-1:0]   idx;
    logic [TIMER_W-1:0]     timer;
    logic [LOG_DEPTH:0]     last_idx;
    logic                   at_last;
    logic                   write_en;
    logic [LOG_DEPTH-1:0]   read_addr;
    logic [N-1:0]           read_data;

    assign last_idx = length - ONE;
    assign at_last  = ({1'b0, idx} == last_idx);
    // Appends only land while idle and not full; the tail slot is length.
    assign write_en = (state == IDLE) && append && !full;

    // Read address: slot 0 when launching playback, the next slot while in
    // GAP (so the following SHOW can register it), otherwise the current one.
    always_comb begin
        read_addr = idx;
        if (state == IDLE) begin
            read_addr = '0;
        end else if (state == GAP) begin
            read_addr = idx + 1'b1;
        end
    end

    sequence_ram #(
        .N         (N),
        .DEPTH     (DEPTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_ram (
        .clock      (clock),
        .write_en   (write_en),
        .write_addr (length[LOG_DEPTH-1:0]),
        .write_data (symbol_in),
        .read_addr  (read_addr),
        .read_data  (read_data)
    );

    // Playback / checking FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            timer       <= '0;
            length      <= '0;
            full        <= 1'b0;
            show_valid  <= 1'b0;
            show_symbol <= '0;
            busy        <= 1'b0;
            round_ok    <= 1'b0;
            mismatch    <= 1'b0;
        end else begin
            round_ok <= 1'b0;
            mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    // append has priority: a simultaneous start is dropped
                    if (append) begin
                        if (!full) begin
                            length <= length + ONE;
                            full   <= (length == DEPTH_M1);
                        end
                    end else if (start && (length != '0)) begin
                        idx         <= '0;
                        timer       <= '0;
                        state       <= SHOW;
                        show_valid  <= 1'b1;
                        show_symbol <= read_data;
                        busy        <= 1'b1;
                    end
                end
                SHOW: begin
                    if (timer == SHOW_LAST) begin
                        timer       <= '0;
                        state       <= GAP;
                        show_valid  <= 1'b0;
                        show_symbol <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        if (at_last) begin
                            idx   <= '0;
                            state <= WAIT_INPUT;
                        end else begin
                            idx         <= idx + 1'b1;
                            state       <= SHOW;
                            show_valid  <= 1'b1;
                            show_symbol <= read_data;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_INPUT: begin
                    if (press) begin
                        if (press_symbol == read_data) begin
                            if (at_last) begin
                                round_ok <= 1'b1;
                                busy     <= 1'b0;
                                idx      <= '0;
                                state    <= IDLE;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            // wrong press ends the game: sequence is discarded
                            mismatch <= 1'b1;
                            length   <= '0;
                            full     <= 1'b0;
                            busy     <= 1'b0;
                            idx      <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_player.sv
// Self-checking bench for sequence_player: appends, full playback timing,
// correct/incorrect press rounds, full sequence, ignored inputs, mid-run reset.
module tb_sequence_player;

    localparam int N           = 3;
    localparam int DEPTH       = 16;
    localparam int LOG_DEPTH   = 4;
    localparam int SHOW_CYCLES = 8;
    localparam int GAP_CYCLES  = 2;
    localparam int SLOT        = SHOW_CYCLES + GAP_CYCLES;

    logic               clock;
    logic               reset;
    logic               append;
    logic [N-1:0]       symbol_in;
    logic               start;
    logic               press;
    logic [N-1:0]       press_symbol;
    logic               show_valid;
    logic [N-1:0]       show_symbol;
    logic               busy;
    logic               round_ok;
    logic               mismatch;
    logic               full;
    logic [LOG_DEPTH:0] length;

    int checks = 0;
    int errors = 0;

    // reference model: stored sequence, checking position, waiting-for-input flag
    logic [N-1:0] model_mem[$];
    int           model_idx;
    bit           model_wait;

    // scoreboard queues: symbols expected on the display, press responses
    logic [N-1:0] exp_q[$];
    logic [1:0]   resp_q[$];

    sequence_player #(
        .N           (N),
        .DEPTH       (DEPTH),
        .LOG_DEPTH   (LOG_DEPTH),
        .SHOW_CYCLES (SHOW_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .append       (append),
        .symbol_in    (symbol_in),
        .start        (start),
        .press        (press),
        .press_symbol (press_symbol),
        .show_valid   (show_valid),
        .show_symbol  (show_symbol),
        .busy         (busy),
        .round_ok     (round_ok),
        .mismatch     (mismatch),
        .full         (full),
        .length       (length)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_show_valid"},  32'(show_valid),  32'(0));
        check({tag, "_show_symbol"}, 32'(show_symbol), 32'(0));
        check({tag, "_busy"},        32'(busy),        32'(0));
        check({tag, "_round_ok"},    32'(round_ok),    32'(0));
        check({tag, "_mismatch"},    32'(mismatch),    32'(0));
    endtask

    // driver: one-cycle append pulse
    task automatic do_append(input logic [N-1:0] sym);
        append    = 1'b1;
        symbol_in = sym;
        step();
        append = 1'b0;
        if (!model_wait && model_mem.size() < DEPTH) model_mem.push_back(sym);
        check("append_length", 32'(length), 32'(model_mem.size()));
        check("append_full",   32'(full),   32'(model_mem.size() == DEPTH));
    endtask

    // driver: one-cycle start pulse, then follow the whole playback cycle by cycle
    task automatic do_start();
        logic [N-1:0] cur;
        bit           go;
        bit           ev;
        cur = '0;
        go  = !model_wait && (model_mem.size() > 0);
        if (go) foreach (model_mem[i]) exp_q.push_back(model_mem[i]);
        start = 1'b1;
        step();
        start = 1'b0;
        if (go) begin
            model_wait = 1'b1;
            model_idx  = 0;
            for (int c = 0; c < model_mem.size() * SLOT; c++) begin
                if (c % SLOT == 0) cur = exp_q.pop_front();
                ev = (c % SLOT) < SHOW_CYCLES;
                check("play_show_valid",  32'(show_valid),  32'(ev));
                check("play_show_symbol", 32'(show_symbol), ev ? 32'(cur) : 32'(0));
                check("play_busy",        32'(busy),        32'(1));
                step();
            end
            check("wait_busy",       32'(busy),       32'(1));
            check("wait_show_valid", 32'(show_valid), 32'(0));
        end else begin
            for (int c = 0; c < 4; c++) begin
                check("ignored_start_valid", 32'(show_valid), 32'(0));
                check("ignored_start_busy",  32'(busy),       32'(model_wait));
                step();
            end
        end
    endtask

    // driver: one-cycle press pulse, response checked right after the sampling edge
    task automatic do_press(input logic [N-1:0] sym);
        logic [1:0] exp;
        logic [1:0] r;
        exp = 2'b00;
        if (model_wait) begin
            if (sym == model_mem[model_idx]) begin
                if (model_idx == model_mem.size() - 1) begin
                    exp        = 2'b10;
                    model_wait = 1'b0;
                end else begin
                    model_idx++;
                end
            end else begin
                exp        = 2'b01;
                model_wait = 1'b0;
                model_mem.delete();
            end
        end
        resp_q.push_back(exp);
        press        = 1'b1;
        press_symbol = sym;
        step();
        press = 1'b0;
        r = resp_q.pop_front();
        check("press_round_ok", 32'(round_ok), 32'(r[1]));
        check("press_mismatch", 32'(mismatch), 32'(r[0]));
        check("press_length",   32'(length),   32'(model_mem.size()));
        check("press_busy",     32'(busy),     32'(model_wait));
    endtask

    // one quiet cycle: result pulses must have dropped
    task automatic quiet();
        step();
        check("pulse_round_ok", 32'(round_ok), 32'(0));
        check("pulse_mismatch", 32'(mismatch), 32'(0));
    endtask

    initial begin
        logic [N-1:0] seq[$];
        reset        = 1'b1;
        append       = 1'b0;
        symbol_in    = '0;
        start        = 1'b0;
        press        = 1'b0;
        press_symbol = '0;
        model_wait   = 1'b0;
        model_idx    = 0;
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        check("reset_full",   32'(full),   32'(0));
        check("reset_length", 32'(length), 32'(0));
        reset = 1'b0;
        step();

        // basic round: 5, 2, 7
        do_append(3'd5);
        do_append(3'd2);
        do_append(3'd7);
        check_idle_outputs("after_append");
        do_start();
        do_press(3'd5);
        do_press(3'd2);
        do_press(3'd7);
        quiet();
        check("round_length", 32'(length), 32'(3));

        // next round one longer, append during WAIT_INPUT ignored, then wrong press
        do_append(3'd1);
        do_start();
        do_append(3'd6);
        do_press(3'd5);
        do_press(3'd3);
        quiet();
        do_press(3'd5);
        check_idle_outputs("after_mismatch");

        // start with empty sequence is ignored
        do_start();

        // fill to DEPTH, 17th append ignored
        for (int i = 0; i < DEPTH + 1; i++) do_append(N'($urandom_range(0, 7)));
        check("full_flag", 32'(full), 32'(1));
        do_press(3'd2);
        check_idle_outputs("press_in_idle");

        // play and correctly answer the full-depth sequence
        seq = model_mem;
        do_start();
        foreach (seq[i]) do_press(seq[i]);
        quiet();
        check("full_round_length", 32'(length), 32'(DEPTH));

        // reset in the middle of SHOW aborts immediately
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mid_show_valid", 32'(show_valid), 32'(1));
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        check("mid_reset_length", 32'(length), 32'(0));
        check("mid_reset_full",   32'(full),   32'(0));
        model_mem.delete();
        model_wait = 1'b0;
        step();
        reset = 1'b0;
        step();
        do_start();
        do_append(3'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
